loc_scanner: RTL and testbench
==============================

LOC_SCANNER -- requirements
Module: loc_scanner

Interface
REQ-001 Parameter PIXELS_X, default 160, grid width in cells.
REQ-002 Parameter PIXELS_Y, default 120, grid height in cells.
REQ-003 Parameter X_bits, default 8, width of x coordinates.
REQ-004 Parameter Y_bits, default 7, width of y coordinates.
REQ-005 Parameter LEAD_bits, default 15, width of lead counter; SHALL satisfy 2^LEAD_bits > PIXELS_X*PIXELS_Y.
REQ-006 Clk  in  1  single clock; all state changes on posedge Clk.
REQ-007 Reset_n  in  1  asynchronous, active-low reset.
REQ-008 restart  in  1  synchronous return of both scanners to (0,0).
REQ-009 HOLD_VIEWLOC  in  1  1 = view scanner frozen.
REQ-010 HOLD_WRITELOC  in  1  1 = write scanner frozen.
REQ-011 clr_overrun  in  1  synchronous clear of overrun flag.
REQ-012 viewLoc_x / viewLoc_y  out  X_bits / Y_bits  current read (view) cell.
REQ-013 writeLoc_x / writeLoc_y  out  X_bits / Y_bits  current write-back cell.
REQ-014 view_wrap / write_wrap  out  1  one-cycle pulse on frame wrap of that scanner.
REQ-015 lead  out  LEAD_bits  view steps minus write steps since restart.
REQ-016 overrun  out  1  sticky ordering-violation flag.

Function
REQ-017 Raster order: x increments 0..PIXELS_X-1; at x=PIXELS_X-1, x->0 and y increments; at (PIXELS_X-1, PIXELS_Y-1), the next step goes to (0,0).
REQ-018 View step request = ~HOLD_VIEWLOC; write step request = ~HOLD_WRITELOC; each granted step advances its scanner one cell on the next posedge.
REQ-019 Write request with lead==0 and no granted view step: write step suppressed, overrun set.
REQ-020 View request with lead==PIXELS_X*PIXELS_Y-1 and no granted write step: view step suppressed, overrun set.
REQ-021 Both granted in the same cycle: both advance, lead unchanged.
REQ-022 Lead update: view-only step +1, write-only step -1, otherwise unchanged.
REQ-023 lead==0 with both requested: both granted; write never passes view.
REQ-024 view_wrap SHALL be 1 in the cycle after a granted view step from (PIXELS_X-1, PIXELS_Y-1); write_wrap likewise; otherwise 0.
REQ-025 restart=1 sets both scanners to (0,0), lead to 0 and wrap pulses to 0, overriding all step requests; overrun unaffected.
REQ-026 clr_overrun=1 clears overrun unless a new violation occurs the same cycle, in which case overrun stays 1 (set wins).
REQ-027 All outputs registered; no combinational path from inputs to outputs.
REQ-028 Coordinates never leave 0..PIXELS_X-1 / 0..PIXELS_Y-1.

Reset
REQ-029 Reset_n low asynchronously forces viewLoc=(0,0), writeLoc=(0,0), lead=0, overrun=0, view_wrap=0, write_wrap=0.
REQ-030 Reset asserted mid-scan aborts immediately; first step after release starts from (0,0).

Verification
REQ-031 Reset released, HOLD_VIEWLOC=0, HOLD_WRITELOC=1 for 3 cycles -> view=(3,0), write=(0,0), lead=3.
REQ-032 Then HOLD_WRITELOC=0 for 160 cycles -> view=(3,1), write=(0,1), lead=3, no wrap pulses.
REQ-033 From reset, HOLD_VIEWLOC=1, HOLD_WRITELOC=0 -> write stays (0,0), overrun=1 next cycle; clr_overrun with holds=1 -> overrun=0.
REQ-034 View-only for 19199 steps -> view=(159,119), lead=19199; one more view-only request -> view held at (159,119), overrun=1; both released for 1 cycle -> view=(0,0) with view_wrap=1, write=(1,0), lead=19199.
REQ-035 restart asserted with both holds released at view=(10,5) -> next cycle both (0,0), lead=0.
REQ-036 Reset_n pulsed low between clock edges mid-scan -> all outputs zero without waiting for a clock edge.

Source files
------------

// File: rtl/loc_scanner.sv
// loc_scanner: paired raster scanners (view = read, write = write-back) over a
// PIXELS_X x PIXELS_Y grid. The write scanner may never pass the view scanner,
// and the view scanner may never lap the write scanner by a full frame. Any
// request that would break that ordering is suppressed and latches overrun.
module loc_scanner #(
  parameter int unsigned PIXELS_X  = 160,
  parameter int unsigned PIXELS_Y  = 120,
  parameter int unsigned X_bits    = 8,
  parameter int unsigned Y_bits    = 7,
  parameter int unsigned LEAD_bits = 15
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 restart,
  input  logic                 HOLD_VIEWLOC,
  input  logic                 HOLD_WRITELOC,
  input  logic                 clr_overrun,
  output logic [X_bits-1:0]    viewLoc_x,
  output logic [Y_bits-1:0]    viewLoc_y,
  output logic [X_bits-1:0]    writeLoc_x,
  output logic [Y_bits-1:0]    writeLoc_y,
  output logic                 view_wrap,
  output logic                 write_wrap,
  output logic [LEAD_bits-1:0] lead,
  output logic                 overrun
);

  localparam int unsigned TOTAL_CELLS = PIXELS_X * PIXELS_Y;

  localparam logic [X_bits-1:0]    X_LAST    = X_bits'(PIXELS_X - 1);
  localparam logic [Y_bits-1:0]    Y_LAST    = Y_bits'(PIXELS_Y - 1);
  localparam logic [LEAD_bits-1:0] LEAD_FULL = LEAD_bits'(TOTAL_CELLS - 1);
  localparam logic [LEAD_bits-1:0] LEAD_ONE  = LEAD_bits'(1);

  // Registered state
  logic [X_bits-1:0]    view_x_q,  view_x_d;
  logic [Y_bits-1:0]    view_y_q,  view_y_d;
  logic [X_bits-1:0]    write_x_q, write_x_d;
  logic [Y_bits-1:0]    write_y_q, write_y_d;
  logic                 view_wrap_q,  view_wrap_d;
  logic                 write_wrap_q, write_wrap_d;
  logic [LEAD_bits-1:0] lead_q, lead_d;
  logic                 overrun_q, overrun_d;

  // Combinational step arbitration
  logic view_req_c;
  logic write_req_c;
  logic lead_zero_c;
  logic lead_full_c;
  logic view_grant_c;
  logic write_grant_c;
  logic violation_c;
  logic view_at_end_c;
  logic write_at_end_c;

  // Grant arbitration: a step that would break view/write ordering is dropped
  always_comb begin
    view_req_c    = ~HOLD_VIEWLOC;
    write_req_c   = ~HOLD_WRITELOC;
    lead_zero_c   = (lead_q == '0);
    lead_full_c   = (lead_q == LEAD_FULL);
    // At full lead the view may only move if the write moves with it; at
    // full lead lead is nonzero, so the write request is granted as-is.
    view_grant_c  = view_req_c & (~lead_full_c | write_req_c);
    // At zero lead the write may only move alongside a granted view step.
    write_grant_c = write_req_c & (~lead_zero_c | view_grant_c);
    violation_c   = (view_req_c & ~view_grant_c) | (write_req_c & ~write_grant_c);
    view_at_end_c  = (view_x_q == X_LAST) & (view_y_q == Y_LAST);
    write_at_end_c = (write_x_q == X_LAST) & (write_y_q == Y_LAST);
  end

  // Next-state for both scanners, lead counter, wrap pulses and overrun flag
  always_comb begin
    view_x_d     = view_x_q;
    view_y_d     = view_y_q;
    write_x_d    = write_x_q;
    write_y_d    = write_y_q;
    view_wrap_d  = 1'b0;
    write_wrap_d = 1'b0;
    lead_d       = lead_q;
    overrun_d    = overrun_q;

    if (restart) begin
      // Restart overrides every step request; overrun only follows clr_overrun
      view_x_d  = '0;
      view_y_d  = '0;
      write_x_d = '0;
      write_y_d = '0;
      lead_d    = '0;
      if (clr_overrun) begin
        overrun_d = 1'b0;
      end
    end else begin
      if (view_grant_c) begin
        if (view_x_q == X_LAST) begin
          view_x_d = '0;
          if (view_y_q == Y_LAST) begin
            view_y_d = '0;
          end else begin
            view_y_d = view_y_q + Y_bits'(1);
          end
        end else begin
          view_x_d = view_x_q + X_bits'(1);
        end
        view_wrap_d = view_at_end_c;
      end

      if (write_grant_c) begin
        if (write_x_q == X_LAST) begin
          write_x_d = '0;
          if (write_y_q == Y_LAST) begin
            write_y_d = '0;
          end else begin
            write_y_d = write_y_q + Y_bits'(1);
          end
        end else begin
          write_x_d = write_x_q + X_bits'(1);
        end
        write_wrap_d = write_at_end_c;
      end

      // Lead tracks view steps minus write steps; simultaneous steps cancel
      if (view_grant_c & ~write_grant_c) begin
        lead_d = lead_q + LEAD_ONE;
      end else if (write_grant_c & ~view_grant_c) begin
        lead_d = lead_q - LEAD_ONE;
      end

      // A fresh violation wins over a same-cycle clear
      if (violation_c) begin
        overrun_d = 1'b1;
      end else if (clr_overrun) begin
        overrun_d = 1'b0;
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      view_x_q     <= '0;
      view_y_q     <= '0;
      write_x_q    <= '0;
      write_y_q    <= '0;
      view_wrap_q  <= 1'b0;
      write_wrap_q <= 1'b0;
      lead_q       <= '0;
      overrun_q    <= 1'b0;
    end else begin
      view_x_q     <= view_x_d;
      view_y_q     <= view_y_d;
      write_x_q    <= write_x_d;
      write_y_q    <= write_y_d;
      view_wrap_q  <= view_wrap_d;
      write_wrap_q <= write_wrap_d;
      lead_q       <= lead_d;
      overrun_q    <= overrun_d;
    end
  end

  // Outputs come straight from flops
  assign viewLoc_x  = view_x_q;
  assign viewLoc_y  = view_y_q;
  assign writeLoc_x = write_x_q;
  assign writeLoc_y = write_y_q;
  assign view_wrap  = view_wrap_q;
  assign write_wrap = write_wrap_q;
  assign lead       = lead_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_loc_scanner.sv
// Bench for loc_scanner: frame-position reference model plus directed scenarios
// and randomized hold/restart/clear traffic.
module tb_loc_scanner;

  localparam int PX    = 160;
  localparam int PY    = 120;
  localparam int TOTAL = PX * PY;

  logic        Clk;
  logic        Reset_n;
  logic        restart;
  logic        HOLD_VIEWLOC;
  logic        HOLD_WRITELOC;
  logic        clr_overrun;
  logic [7:0]  viewLoc_x;
  logic [6:0]  viewLoc_y;
  logic [7:0]  writeLoc_x;
  logic [6:0]  writeLoc_y;
  logic        view_wrap;
  logic        write_wrap;
  logic [14:0] lead;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  loc_scanner dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .restart       (restart),
    .HOLD_VIEWLOC  (HOLD_VIEWLOC),
    .HOLD_WRITELOC (HOLD_WRITELOC),
    .clr_overrun   (clr_overrun),
    .viewLoc_x     (viewLoc_x),
    .viewLoc_y     (viewLoc_y),
    .writeLoc_x    (writeLoc_x),
    .writeLoc_y    (writeLoc_y),
    .view_wrap     (view_wrap),
    .write_wrap    (write_wrap),
    .lead          (lead),
    .overrun       (overrun)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: each scanner is a linear position within the frame
  int m_vpos, m_wpos, m_lead;
  bit m_ovr, m_vwrap, m_wwrap;

  always @(posedge Clk or negedge Reset_n) begin
    bit vreq, wreq, vg, wg;
    if (!Reset_n) begin
      m_vpos = 0; m_wpos = 0; m_lead = 0;
      m_ovr = 0; m_vwrap = 0; m_wwrap = 0;
    end else if (restart) begin
      m_vpos = 0; m_wpos = 0; m_lead = 0;
      m_vwrap = 0; m_wwrap = 0;
      if (clr_overrun) m_ovr = 0;
    end else begin
      vreq = !HOLD_VIEWLOC;
      wreq = !HOLD_WRITELOC;
      // write may not pass view; view may not get a whole frame ahead
      vg = vreq && ((m_lead < TOTAL - 1) || wreq);
      wg = wreq && ((m_lead > 0) || vg);
      m_vwrap = vg && (m_vpos == TOTAL - 1);
      m_wwrap = wg && (m_wpos == TOTAL - 1);
      if (vg) m_vpos = (m_vpos + 1) % TOTAL;
      if (wg) m_wpos = (m_wpos + 1) % TOTAL;
      m_lead = m_lead + int'(vg) - int'(wg);
      if ((vreq && !vg) || (wreq && !wg)) m_ovr = 1;
      else if (clr_overrun) m_ovr = 0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge
  always @(negedge Clk) begin
    chk("view_x",     int'(viewLoc_x),  m_vpos % PX);
    chk("view_y",     int'(viewLoc_y),  m_vpos / PX);
    chk("write_x",    int'(writeLoc_x), m_wpos % PX);
    chk("write_y",    int'(writeLoc_y), m_wpos / PX);
    chk("lead",       int'(lead),       m_lead);
    chk("view_wrap",  int'(view_wrap),  int'(m_vwrap));
    chk("write_wrap", int'(write_wrap), int'(m_wwrap));
    chk("overrun",    int'(overrun),    int'(m_ovr));
  end

  task automatic drive(input bit hv, input bit hw, input bit rs, input bit clr);
    HOLD_VIEWLOC  = hv;
    HOLD_WRITELOC = hw;
    restart       = rs;
    clr_overrun   = clr;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic expect_state(input string tag, input int vx, input int vy,
                              input int wx, input int wy, input int ld,
                              input int vw, input int ww, input int ov);
    chk({tag, "_view_x"},  int'(viewLoc_x),  vx);
    chk({tag, "_view_y"},  int'(viewLoc_y),  vy);
    chk({tag, "_write_x"}, int'(writeLoc_x), wx);
    chk({tag, "_write_y"}, int'(writeLoc_y), wy);
    chk({tag, "_lead"},    int'(lead),       ld);
    chk({tag, "_vwrap"},   int'(view_wrap),  vw);
    chk({tag, "_wwrap"},   int'(write_wrap), ww);
    chk({tag, "_overrun"}, int'(overrun),    ov);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    drive(1, 1, 0, 0);
    cycles(2);
    Reset_n = 1'b1;
    cycles(1);
  endtask

  initial begin
    Reset_n = 1'b0;
    drive(1, 1, 0, 0);
    do_reset();
    expect_state("reset", 0, 0, 0, 0, 0, 0, 0, 0);

    // View runs ahead three cells
    drive(0, 1, 0, 0);
    cycles(3);
    drive(1, 1, 0, 0);
    expect_state("view3", 3, 0, 0, 0, 3, 0, 0, 0);

    // Both run one full row in lockstep
    drive(0, 0, 0, 0);
    cycles(160);
    drive(1, 1, 0, 0);
    expect_state("row", 3, 1, 0, 1, 3, 0, 0, 0);

    // Write alone at zero lead is refused and flags overrun
    do_reset();
    drive(1, 0, 0, 0);
    cycles(1);
    drive(1, 1, 0, 1);
    expect_state("wblock", 0, 0, 0, 0, 0, 0, 0, 1);
    cycles(1);
    drive(1, 1, 0, 0);
    expect_state("clr", 0, 0, 0, 0, 0, 0, 0, 0);

    // View runs a whole frame minus one ahead, then is refused
    drive(0, 1, 0, 0);
    cycles(TOTAL - 1);
    expect_state("vfull", 159, 119, 0, 0, TOTAL - 1, 0, 0, 0);
    cycles(1);
    drive(1, 1, 0, 0);
    expect_state("vblock", 159, 119, 0, 0, TOTAL - 1, 0, 0, 1);
    drive(0, 0, 0, 0);
    cycles(1);
    drive(1, 1, 0, 0);
    expect_state("vwrap", 0, 0, 1, 0, TOTAL - 1, 1, 0, 1);
    cycles(1);
    chk("vwrap_pulse_end", int'(view_wrap), 0);

    // Restart from mid-frame; overrun is left alone
    drive(1, 1, 1, 0);
    cycles(1);
    drive(0, 1, 0, 0);
    cycles(5 * PX + 10);
    drive(0, 0, 0, 0);
    chk("pre_restart_vx", int'(viewLoc_x), 10);
    chk("pre_restart_vy", int'(viewLoc_y), 5);
    drive(0, 0, 1, 0);
    cycles(1);
    drive(1, 1, 0, 0);
    expect_state("restart", 0, 0, 0, 0, 0, 0, 0, 1);

    // Randomized traffic in segments with different hold biases
    for (int seg = 0; seg < 30; seg++) begin
      int vbias, wbias;
      vbias = $urandom_range(10, 90);
      wbias = $urandom_range(10, 90);
      for (int c = 0; c < 100; c++) begin
        drive($urandom_range(0, 99) >= vbias, $urandom_range(0, 99) >= wbias,
              $urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0);
        cycles(1);
      end
    end

    // Drive the write scanner across its own frame wrap
    drive(1, 1, 1, 1);
    cycles(1);
    drive(0, 0, 0, 0);
    cycles(TOTAL);
    drive(1, 1, 0, 0);
    expect_state("lockstep_frame", 0, 0, 0, 0, 0, 1, 1, 0);

    // Asynchronous reset mid-scan, between clock edges
    drive(0, 1, 0, 0);
    cycles(37);
    #2;
    Reset_n = 1'b0;
    #1;
    expect_state("async_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    Reset_n = 1'b1;
    cycles(2);
    drive(1, 1, 0, 0);
    expect_state("post_rst", 2, 0, 0, 0, 2, 0, 0, 0);
    cycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
